// File: rtl/mpu_pkg.sv
// Shared constants for the MPU command path: opcodes, FSM encoding, result width.
package mpu_pkg;

  localparam int RES_W = 16;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_MUL = 8'h05;

  localparam logic [RES_W-1:0] ERR_RESULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_A   = 3'd1,
    ST_GET_B   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_WAIT_HI = 3'd5,
    ST_SEND_LO = 3'd6,
    ST_WAIT_LO = 3'd7
  } state_t;

endpackage

// File: rtl/mpu_alu.sv
// Combinational 8-bit ALU producing a 16-bit result; unknown opcodes give ERR_RESULT.
// Zero latency, no handshake.
module mpu_alu
  import mpu_pkg::*;
(
  input  logic [7:0]       i_op,
  input  logic [7:0]       i_a,
  input  logic [7:0]       i_b,
  output logic [RES_W-1:0] o_result,
  output logic             o_invalid
);

  always_comb begin
    o_result  = '0;
    o_invalid = 1'b0;
    case (i_op)
      OP_ADD:  o_result = {7'd0, {1'b0, i_a} + {1'b0, i_b}};
      // Zero-extended operands give the sign-extended 16-bit difference.
      OP_SUB:  o_result = {8'd0, i_a} - {8'd0, i_b};
      OP_AND:  o_result = {8'd0, i_a & i_b};
      OP_OR:   o_result = {8'd0, i_a | i_b};
      OP_XOR:  o_result = {8'd0, i_a ^ i_b};
      OP_MUL:  o_result = 16'(i_a) * 16'(i_b);
      default: begin
        o_result  = ERR_RESULT;
        o_invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mpu_cmd_ctrl.sv
// Collects opcode/A/B frames from the UART receiver, executes them and returns the 16-bit result MSB first.
// First tx byte two cycles after the last rx byte; each tx byte is held until its i_tx_complete.
module mpu_cmd_ctrl
  import mpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 17361
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_rx_d,
  input  logic       i_rx_complete,
  input  logic       i_rx_error,
  input  logic       i_tx_complete,
  output logic [7:0] o_tx_d,
  output logic       o_tx_en,
  output logic       o_busy,
  output logic       o_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;

  logic [7:0]       op_q, a_q, b_q;
  logic [RES_W-1:0] res_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic [RES_W-1:0] alu_res;
  logic             alu_invalid;

  logic       rx_phase, accept, timeout;
  logic [7:0] tx_d_nxt;
  logic       tx_en_nxt, busy_nxt, err_nxt;

  mpu_alu u_alu (
    .i_op      (op_q),
    .i_a       (a_q),
    .i_b       (b_q),
    .o_result  (alu_res),
    .o_invalid (alu_invalid)
  );

  // A byte flagged with a receive error is never taken.
  assign rx_phase = (state == ST_IDLE) || (state == ST_GET_A) || (state == ST_GET_B);
  assign accept   = rx_phase && i_rx_complete && !i_rx_error;
  assign timeout  = ((state == ST_GET_A) || (state == ST_GET_B)) && (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_GET_A;
      ST_GET_A: begin
        if (i_rx_error)   state_nxt = ST_IDLE;
        else if (accept)  state_nxt = ST_GET_B;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_GET_B: begin
        if (i_rx_error)   state_nxt = ST_IDLE;
        else if (accept)  state_nxt = ST_EXEC;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_EXEC:    state_nxt = ST_SEND_HI;
      ST_SEND_HI: state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (i_tx_complete) state_nxt = ST_SEND_LO;
      ST_SEND_LO: state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (i_tx_complete) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_comb begin
    tx_en_nxt = (state_nxt == ST_SEND_HI) || (state_nxt == ST_SEND_LO);
    busy_nxt  = (state_nxt == ST_EXEC)    || (state_nxt == ST_SEND_HI) ||
                (state_nxt == ST_WAIT_HI) || (state_nxt == ST_SEND_LO) ||
                (state_nxt == ST_WAIT_LO);
    err_nxt   = (rx_phase && i_rx_error) ||
                (timeout && !i_rx_complete) ||
                ((state == ST_GET_B) && accept && alu_invalid);
    tx_d_nxt  = o_tx_d;
    if (state == ST_EXEC)         tx_d_nxt = alu_res[15:8];
    else if (state == ST_WAIT_HI) tx_d_nxt = i_tx_complete ? res_q[7:0] : o_tx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tx_d  <= 8'h00;
      o_tx_en <= 1'b0;
      o_busy  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_tx_d  <= tx_d_nxt;
      o_tx_en <= tx_en_nxt;
      o_busy  <= busy_nxt;
      o_err   <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      res_q <= '0;
    end else begin
      if (accept && (state == ST_IDLE))  op_q <= i_rx_d;
      if (accept && (state == ST_GET_A)) a_q  <= i_rx_d;
      if (accept && (state == ST_GET_B)) b_q  <= i_rx_d;
      if (state == ST_EXEC)              res_q <= alu_res;
    end
  end

  // Counts idle cycles only while a frame is partially received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt <= '0;
    else if (accept || ((state_nxt != ST_GET_A) && (state_nxt != ST_GET_B)))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

endmodule

// File: doc/mpu_cmd_ctrl.md
# mpu_cmd_ctrl

Command controller for the simple MPU. It sits between the UART receiver and the UART transmitter. It collects 3-byte command frames (opcode, operand A, operand B) from the receiver, executes the operation on an 8-bit ALU, and returns the 16-bit result as two bytes through a transmit handshake. It also handles receive errors, inter-byte timeouts and invalid opcodes.

## Interface
- TIMEOUT_CYC, 17361, maximum idle cycles allowed between bytes of one frame (about 4 byte-times at 50 MHz / 115200 baud).
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_rx_d  in  8  received byte; valid in the cycle i_rx_complete is high.
- i_rx_complete  in  1  one-cycle pulse per received byte.
- i_rx_error  in  1  one-cycle pulse (framing/stop error) for the current byte.
- i_tx_complete  in  1  one-cycle pulse when the transmitter finishes a byte.
- o_tx_d  out  8  byte to transmit; held stable from o_tx_en until the matching i_tx_complete.
- o_tx_en  out  1  one-cycle transmit request.
- o_busy  out  1  high from EXEC through WAIT_LO.
- o_err  out  1  one-cycle pulse on any dropped or invalid frame.

## Operation
- States: IDLE → GET_A → GET_B → EXEC → SEND_HI → WAIT_HI → SEND_LO → WAIT_LO → IDLE.
- IDLE: an i_rx_complete pulse latches the opcode and moves to GET_A. GET_A latches A and moves to GET_B. GET_B latches B and moves to EXEC.
- Opcodes: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 MUL.
- Result widths:
  - ADD: 9-bit sum, zero-extended to 16 bits.
  - SUB: A−B as a 16-bit two's complement, sign-extended.
  - AND/OR/XOR: zero-extended to 16 bits.
  - MUL: 16-bit unsigned product.
- Any other opcode produces result 0xFFFF and an o_err pulse in EXEC. The response is still sent.
- EXEC registers the 16-bit result. SEND_HI drives the high byte with o_tx_en, then waits in WAIT_HI for i_tx_complete. SEND_LO and WAIT_LO do the same for the low byte.
- Receive error: i_rx_error while in IDLE, GET_A or GET_B discards the partial frame, returns to IDLE and pulses o_err. If i_rx_error and i_rx_complete arrive in the same cycle, the error wins and the byte is not latched.
- Timeout: a counter clears on every accepted byte and counts only in GET_A and GET_B. When it reaches TIMEOUT_CYC−1, the FSM returns to IDLE and pulses o_err.
- Ignored inputs:
  - i_rx_complete from EXEC through WAIT_LO is dropped silently, with no o_err.
  - i_tx_complete outside WAIT_HI and WAIT_LO has no effect.
- Reset mid-operation: the FSM returns to IDLE immediately and any partial frame or pending response is discarded.

## Timing
- Reset values: o_tx_d=0x00, o_tx_en=0, o_busy=0, o_err=0, FSM=IDLE, timeout counter=0.
- Third byte latched on edge N. EXEC runs in cycle N+1. o_tx_en is high with the high byte in cycle N+2.
- i_tx_complete for the high byte seen on edge M. o_tx_en is high with the low byte in cycle M+1.
- i_tx_complete for the low byte moves the FSM to IDLE on the next edge, where a new opcode can be accepted.
- o_err pulses last exactly one cycle.
- o_busy is registered and follows the state with no extra latency.

## Structure
- Shared package mpu_pkg holds:
  - opcode constants;
  - the state encoding;
  - the ERR_RESULT = 16'hFFFF constant;
  - the result width of 16.
- One sub-module, mpu_alu: a combinational 8-bit op/A/B to 16-bit result unit with an o_invalid flag, instantiated once. The FSM, operand/result registers and timeout counter live in mpu_cmd_ctrl.

## Test plan
- ADD frame 0x00,0xF0,0x20 → tx bytes 0x01 then 0x10. o_busy high throughout; o_err never pulses.
- SUB 0x01,0x10,0x20 → 0xFF, 0xF0. MUL 0x05,0xFF,0xFF → 0xFE, 0x01. Transmitter completions are delayed 100 cycles; o_tx_d must stay stable until each completion.
- Invalid opcode 0x09,0x12,0x34 → o_err pulses once, then 0xFF, 0xFF is transmitted.
- i_rx_error on byte 2 of a frame → no o_tx_en and one o_err pulse. A following frame 0x02,0x3C,0x0F returns 0x00, 0x0C.
- Opcode followed by silence for TIMEOUT_CYC cycles → o_err pulse and return to IDLE. Bytes arriving during WAIT_HI are ignored with no o_err.
- rst_n asserted in WAIT_HI → all outputs return to their reset values immediately. After release, a fresh frame completes correctly.
